seg_readback: RTL and testbench

// Reads back the four 7-segment digit buses driven by the CPU datapath and turns them into a 16-bit hex value.

---
 rtl/seg_readback.sv | 122 ++++++++++++
 tb/tb_seg_readback.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg_readback.sv
// seg_readback: samples four 7-segment digit buses and waits until all of
// them hold steady. It then decodes them to a 16-bit hex value. A stable
// pattern that contains a non-hex glyph is reported with a per-digit
// error mask.

// Per-digit glyph decoder: maps one segment pattern to a nibble plus a
// "recognised" flag.
module seg_digit_dec #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       ok
);
  logic [6:0] pat;

  // Normalise to lit=1 (gfedcba), then look the pattern up in the hex glyph table.
  always_comb begin
    pat = (ACTIVE_LOW != 0) ? ~seg : seg;
    nib = 4'h0;
    ok  = 1'b1;
    case (pat)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: ok = 1'b0;
    endcase
  end
endmodule

module seg_readback #(
  parameter int STABLE_CYCLES = 4,  // 1..255 unchanged samples before reporting
  parameter int ACTIVE_LOW    = 1   // 1: segment lit when its bit is 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg0,
  input  logic [6:0]  seg1,
  input  logic [6:0]  seg2,
  input  logic [6:0]  seg3,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        glyph_err,
  output logic [3:0]  err_digit,
  output logic        locked
);
  localparam int NUM_LANES = 4;
  // An all-unlit pattern is never a legal glyph, so it makes a safe reset sample.
  localparam logic [6:0] BLANK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic {SETTLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                          state;
  logic [7:0]                      cnt;
  logic [NUM_LANES-1:0][6:0]       seg_in;
  logic [NUM_LANES-1:0][6:0]       s_q;
  logic [NUM_LANES-1:0][3:0]       nib;
  logic [NUM_LANES-1:0]            ok;

  assign seg_in = {seg3, seg2, seg1, seg0};

  // The decoders look at the held sample, not the live inputs, so any
  // evaluation sees exactly the pattern that was counted as stable.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    seg_digit_dec #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
      .seg (s_q[g]),
      .nib (nib[g]),
      .ok  (ok[g])
    );
  end

  // Stability tracker: restart on any change, and evaluate once after
  // STABLE_CYCLES unchanged samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SETTLE;
      cnt         <= 8'd0;
      s_q         <= {NUM_LANES{BLANK}};
      value       <= 16'h0000;
      value_valid <= 1'b0;
      glyph_err   <= 1'b0;
      err_digit   <= 4'h0;
      locked      <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      glyph_err   <= 1'b0;
      if (seg_in != s_q) begin
        s_q    <= seg_in;
        cnt    <= 8'd0;
        state  <= SETTLE;
        locked <= 1'b0;
      end else if (state == SETTLE && cnt == CNT_LAST) begin
        state  <= LOCKED;
        locked <= 1'b1;
        if (&ok) begin
          value       <= nib;
          value_valid <= 1'b1;
          err_digit   <= 4'h0;
        end else begin
          glyph_err <= 1'b1;
          err_digit <= ~ok;
        end
      end else if (state == SETTLE && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_seg_readback.sv
// Bench for seg_readback. It runs a default instance (4 stable cycles,
// active-low segments) and a second instance (1 stable cycle, active-high).
// Expected report pulses are queued when stimulus is driven. A monitor pops
// them when the DUT pulses.
module tb_seg_readback;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg0 = 7'h40, seg1 = 7'h40, seg2 = 7'h40, seg3 = 7'h40;
  logic [15:0] value;
  logic        value_valid, glyph_err, locked;
  logic [3:0]  err_digit;

  logic [6:0]  b_seg0 = 7'h00, b_seg1 = 7'h00, b_seg2 = 7'h00, b_seg3 = 7'h00;
  logic [15:0] b_value;
  logic        b_value_valid, b_glyph_err, b_locked;
  logic [3:0]  b_err_digit;

  int checks = 0;
  int failures = 0;
  int edges = 0;

  seg_readback dut (
    .clk(clk), .rst(rst), .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .value(value), .value_valid(value_valid), .glyph_err(glyph_err),
    .err_digit(err_digit), .locked(locked)
  );

  seg_readback #(.STABLE_CYCLES(1), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .seg0(b_seg0), .seg1(b_seg1), .seg2(b_seg2), .seg3(b_seg3),
    .value(b_value), .value_valid(b_value_valid), .glyph_err(b_glyph_err),
    .err_digit(b_err_digit), .locked(b_locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    int          edge_n;  // edge count at which the pulse must be visible
    int          kind;    // 1 = value_valid, 2 = glyph_err
    logic [15:0] val;
    logic [3:0]  errd;
  } exp_t;

  typedef struct {
    logic [6:0]  s3, s2, s1, s0;
    int          hold;
    int          kind;    // 0 = no pulse expected
    logic [15:0] val;     // value after the hold
    logic [3:0]  errd;
    logic        lk;
  } vec_t;

  exp_t sbq[$];
  exp_t e;
  vec_t tbl[8];
  int   n0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (edge %0d)", nm, act, exp, edges);
    end
  endtask

  // Scoreboard monitor for the default instance.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].edge_n < edges) begin
      checks++;
      failures++;
      $display("FAIL missed_pulse actual=none expected_edge=%0d (edge %0d)", sbq[0].edge_n, edges);
      void'(sbq.pop_front());
    end
    if (value_valid || glyph_err) begin
      chk("pulse_exclusive", {31'b0, value_valid & glyph_err}, 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=%b%b expected=none (edge %0d)", glyph_err, value_valid, edges);
      end else begin
        e = sbq.pop_front();
        chk("pulse_edge", edges, e.edge_n);
        chk("pulse_kind", {30'b0, glyph_err, value_valid}, e.kind);
        chk("pulse_value", {16'b0, value}, {16'b0, e.val});
        chk("pulse_err_digit", {28'b0, err_digit}, {28'b0, e.errd});
      end
    end
  end

  initial begin
    // seg3, seg2, seg1, seg0 (active-low glyphs), hold, kind, value, err_digit, locked
    tbl[0] = '{7'h79, 7'h24, 7'h30, 7'h19, 10, 1, 16'h1234, 4'h0, 1'b1};  // "1234"
    tbl[1] = '{7'h79, 7'h7F, 7'h30, 7'h19,  8, 2, 16'h1234, 4'h4, 1'b1};  // digit2 blank
    tbl[2] = '{7'h08, 7'h12, 7'h0E, 7'h40,  8, 1, 16'hA5F0, 4'h0, 1'b1};  // "A5F0"
    tbl[3] = '{7'h7F, 7'h12, 7'h0E, 7'h55,  8, 2, 16'hA5F0, 4'h9, 1'b1};  // digits 3,0 bad
    tbl[4] = '{7'h08, 7'h12, 7'h0E, 7'h40,  8, 1, 16'hA5F0, 4'h0, 1'b1};  // same value relock
    tbl[5] = '{7'h00, 7'h00, 7'h00, 7'h00,  3, 0, 16'hA5F0, 4'h0, 1'b0};  // too short
    tbl[6] = '{7'h10, 7'h03, 7'h46, 7'h21,  7, 1, 16'h9BCD, 4'h0, 1'b1};  // "9bCd"
    tbl[7] = '{7'h06, 7'h02, 7'h78, 7'h00,  6, 1, 16'hE678, 4'h0, 1'b1};  // "E678"

    // Reset with all digits showing '0'.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_value", {16'b0, value}, 32'h0);
    chk("rst_valid", {31'b0, value_valid}, 32'h0);
    chk("rst_glyph_err", {31'b0, glyph_err}, 32'h0);
    chk("rst_err_digit", {28'b0, err_digit}, 32'h0);
    chk("rst_locked", {31'b0, locked}, 32'h0);
    rst = 1'b0;
    sbq.push_back('{edges + 5, 1, 16'h0000, 4'h0});
    repeat (6) @(negedge clk);
    chk("t1_value", {16'b0, value}, 32'h0000);
    chk("t1_locked", {31'b0, locked}, 32'h1);

    // Table-driven patterns.
    for (int i = 0; i < 8; i++) begin
      {seg3, seg2, seg1, seg0} = {tbl[i].s3, tbl[i].s2, tbl[i].s1, tbl[i].s0};
      n0 = edges;
      if (tbl[i].kind != 0) sbq.push_back('{n0 + 5, tbl[i].kind, tbl[i].val, tbl[i].errd});
      @(negedge clk);
      chk($sformatf("v%0d_locked_drop", i), {31'b0, locked}, 32'h0);
      repeat (tbl[i].hold - 1) @(negedge clk);
      chk($sformatf("v%0d_value", i), {16'b0, value}, {16'b0, tbl[i].val});
      chk($sformatf("v%0d_locked", i), {31'b0, locked}, {31'b0, tbl[i].lk});
      chk($sformatf("v%0d_err_digit", i), {28'b0, err_digit}, {28'b0, tbl[i].errd});
    end

    // Toggling digit 0 faster than the stability window never reports.
    {seg3, seg2, seg1} = {7'h79, 7'h24, 7'h30};
    for (int i = 0; i < 6; i++) begin
      seg0 = (i % 2 == 0) ? 7'h79 : 7'h40;
      repeat (2) @(negedge clk);
      chk($sformatf("t3_locked_%0d", i), {31'b0, locked}, 32'h0);
    end
    seg0 = 7'h79;
    sbq.push_back('{edges + 5, 1, 16'h1231, 4'h0});
    repeat (8) @(negedge clk);
    chk("t3_value", {16'b0, value}, 32'h1231);
    chk("t3_locked", {31'b0, locked}, 32'h1);

    // Reset while settling with cnt=2; the count restarts from scratch after release.
    {seg3, seg2, seg1, seg0} = {7'h19, 7'h30, 7'h24, 7'h79};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_value", {16'b0, value}, 32'h0);
    chk("t5_rst_locked", {31'b0, locked}, 32'h0);
    chk("t5_rst_err_digit", {28'b0, err_digit}, 32'h0);
    rst = 1'b0;
    sbq.push_back('{edges + 5, 1, 16'h4321, 4'h0});
    repeat (3) @(negedge clk);
    chk("t5_locked_early", {31'b0, locked}, 32'h0);
    repeat (3) @(negedge clk);
    chk("t5_value", {16'b0, value}, 32'h4321);
    chk("t5_locked", {31'b0, locked}, 32'h1);

    // Active-high instance with a one-cycle stability window.
    {b_seg3, b_seg2, b_seg1, b_seg0} = {7'h71, 7'h5E, 7'h39, 7'h7C};
    @(negedge clk);
    chk("t6_valid_capture", {31'b0, b_value_valid}, 32'h0);
    @(negedge clk);
    chk("t6_valid", {31'b0, b_value_valid}, 32'h1);
    chk("t6_value", {16'b0, b_value}, 32'hFDCB);
    chk("t6_locked", {31'b0, b_locked}, 32'h1);
    @(negedge clk);
    chk("t6_valid_one_cycle", {31'b0, b_value_valid}, 32'h0);
    b_seg0 = 7'h00;
    repeat (2) @(negedge clk);
    chk("t6_glyph_err", {31'b0, b_glyph_err}, 32'h1);
    chk("t6_err_digit", {28'b0, b_err_digit}, 32'h1);
    chk("t6_value_kept", {16'b0, b_value}, 32'hFDCB);
    @(negedge clk);
    chk("t6_err_one_cycle", {31'b0, b_glyph_err}, 32'h0);

    repeat (6) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
